// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command path: arbiter state encoding,
// master command opcodes used by the sensor sequencers, small helpers.
package i2c_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_FLUSH = 2'd2,
    S_GAP   = 2'd3
  } arb_state_e;

  // Register addresses written as command bytes by the MPU6050 sequencer
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;

  function automatic int unsigned max3_u(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One-hot select for a two-client bus
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_tic_timer.sv
// Loadable down-counter that only decrements on TIC and holds at zero.
// done_o is high whenever the count is zero.
module i2c_tic_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tic_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down on TIC, saturating at zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tic_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Two-client arbiter for the single I2C master command port.
// Round-robin grant held for a whole transaction, TIC-based watchdog that
// force-resets the master and reclaims the bus, and an idle gap between owners.
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned WDOG_TICS = 1023,
  parameter int unsigned GAP_TICS  = 2,
  parameter int unsigned SRST_TICS = 4
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        TIC,
  input  logic [1:0]  REQ,
  output logic [1:0]  GNT,
  input  logic [15:0] C_DOUT,
  input  logic [1:0]  C_WE,
  input  logic [1:0]  C_RD,
  input  logic [1:0]  C_SRST,
  output logic [1:0]  C_QUEUED,
  output logic [1:0]  C_NACK,
  output logic [1:0]  C_STOP,
  output logic [1:0]  C_DATA_VALID,
  output logic [7:0]  C_DIN,
  output logic [1:0]  TIMEOUT,
  output logic [7:0]  M_DOUT,
  output logic        M_WE,
  output logic        M_RD,
  output logic        M_SRST,
  input  logic        M_QUEUED,
  input  logic        M_NACK,
  input  logic        M_STOP,
  input  logic        M_DATA_VALID,
  input  logic [7:0]  M_DIN
);

  localparam int unsigned CW = $clog2(max3_u(WDOG_TICS, GAP_TICS, SRST_TICS) + 1);
  localparam logic [CW-1:0] WDOG_LD = CW'(WDOG_TICS);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_TICS);
  localparam logic [CW-1:0] SRST_LD = CW'(SRST_TICS);

  arb_state_e    state_q;
  logic          owner_q;
  logic          last_q;
  logic [1:0]    gnt_q;
  logic [1:0]    timeout_q;

  logic          progress;
  logic          expire;
  logic          winner;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  assign progress = M_QUEUED | M_NACK | M_STOP | M_DATA_VALID;
  // On contention the client that did not own the bus last time wins
  assign winner   = (REQ == 2'b11) ? ~last_q : REQ[1];
  // Expiry outranks a simultaneous REQ drop; a progress event rescues the owner
  assign expire   = (state_q == S_OWN) && tmr_done && !progress;

  // One timer serves watchdog, flush and gap; pick what to load on each transition
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          tmr_load = 1'b1;
          tmr_val  = WDOG_LD;
        end
      end
      S_OWN: begin
        if (expire) begin
          tmr_load = 1'b1;
          tmr_val  = SRST_LD;
        end else if (!REQ[owner_q]) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else if (progress) begin
          tmr_load = 1'b1;
          tmr_val  = WDOG_LD;
        end
      end
      S_FLUSH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      S_GAP: begin
        tmr_load = 1'b0;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  i2c_tic_timer #(
    .W (CW)
  ) u_timer (
    .clk_i      (MCLK),
    .rst_i      (RST),
    .tic_i      (TIC),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Arbitration state machine with registered grant and timeout pulse
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= '0;
      timeout_q <= '0;
    end else begin
      timeout_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (REQ != 2'b00) begin
            owner_q <= winner;
            gnt_q   <= onehot2(winner);
            state_q <= S_OWN;
          end
        end
        S_OWN: begin
          if (expire) begin
            gnt_q     <= '0;
            timeout_q <= onehot2(owner_q);
            last_q    <= owner_q;
            state_q   <= S_FLUSH;
          end else if (!REQ[owner_q]) begin
            gnt_q   <= '0;
            last_q  <= owner_q;
            state_q <= S_GAP;
          end
        end
        S_FLUSH: begin
          if (tmr_done) state_q <= S_GAP;
        end
        S_GAP: begin
          if (tmr_done) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign TIMEOUT = timeout_q;

  // Route command/status between the master and the current owner only
  always_comb begin
    M_DOUT       = '0;
    M_WE         = 1'b0;
    M_RD         = 1'b0;
    M_SRST       = 1'b0;
    C_QUEUED     = '0;
    C_NACK       = '0;
    C_STOP       = '0;
    C_DATA_VALID = '0;
    C_DIN        = '0;
    unique case (state_q)
      S_OWN: begin
        M_DOUT                = owner_q ? C_DOUT[15:8] : C_DOUT[7:0];
        // Gating strobes with REQ blanks them already in the release cycle
        M_WE                  = C_WE[owner_q] & REQ[owner_q];
        M_RD                  = C_RD[owner_q] & REQ[owner_q];
        M_SRST                = C_SRST[owner_q];
        C_QUEUED[owner_q]     = M_QUEUED;
        C_NACK[owner_q]       = M_NACK;
        C_STOP[owner_q]       = M_STOP;
        C_DATA_VALID[owner_q] = M_DATA_VALID;
        C_DIN                 = M_DIN;
      end
      S_FLUSH: begin
        M_SRST = 1'b1;
      end
      default: begin
        M_SRST = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: grant/routing, round-robin, read path,
// watchdog expiry and clear, asynchronous reset.
module tb_i2c_cmd_arbiter;

  localparam int WDOG = 1023;
  localparam int GAP  = 2;
  localparam int SRST = 4;

  logic        MCLK = 1'b0;
  logic        RST  = 1'b1;
  logic        TIC  = 1'b0;
  logic [1:0]  REQ  = '0;
  logic [1:0]  GNT;
  logic [15:0] C_DOUT = '0;
  logic [1:0]  C_WE = '0, C_RD = '0, C_SRST = '0;
  logic [1:0]  C_QUEUED, C_NACK, C_STOP, C_DATA_VALID;
  logic [7:0]  C_DIN;
  logic [1:0]  TIMEOUT;
  logic [7:0]  M_DOUT;
  logic        M_WE, M_RD, M_SRST;
  logic        M_QUEUED = 1'b0, M_NACK = 1'b0, M_STOP = 1'b0, M_DATA_VALID = 1'b0;
  logic [7:0]  M_DIN = '0;

  int total = 0;
  int bad   = 0;
  int tics  = 0;
  int t0, t1, el, nto;

  i2c_cmd_arbiter #(
    .WDOG_TICS (WDOG),
    .GAP_TICS  (GAP),
    .SRST_TICS (SRST)
  ) dut (
    .MCLK         (MCLK),
    .RST          (RST),
    .TIC          (TIC),
    .REQ          (REQ),
    .GNT          (GNT),
    .C_DOUT       (C_DOUT),
    .C_WE         (C_WE),
    .C_RD         (C_RD),
    .C_SRST       (C_SRST),
    .C_QUEUED     (C_QUEUED),
    .C_NACK       (C_NACK),
    .C_STOP       (C_STOP),
    .C_DATA_VALID (C_DATA_VALID),
    .C_DIN        (C_DIN),
    .TIMEOUT      (TIMEOUT),
    .M_DOUT       (M_DOUT),
    .M_WE         (M_WE),
    .M_RD         (M_RD),
    .M_SRST       (M_SRST),
    .M_QUEUED     (M_QUEUED),
    .M_NACK       (M_NACK),
    .M_STOP       (M_STOP),
    .M_DATA_VALID (M_DATA_VALID),
    .M_DIN        (M_DIN)
  );

  always #5 MCLK = ~MCLK;

  // TIC high for one MCLK out of every three
  initial begin : ticgen
    int d;
    d = 0;
    forever begin
      @(negedge MCLK);
      d   = (d + 1) % 3;
      TIC = (d == 0);
    end
  end

  // Count TICs as the DUT sees them
  always @(posedge MCLK) if (TIC) tics <= tics + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bounded wait on negedges: 0 = any grant, 1 = any timeout, 2 = SRST low
  task automatic wait_cond(input int which, input int lim);
    int n;
    n = 0;
    forever begin
      if (which == 0 && GNT != 2'b00) break;
      if (which == 1 && TIMEOUT != 2'b00) break;
      if (which == 2 && !M_SRST) break;
      if (n >= lim) break;
      @(negedge MCLK);
      n++;
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge MCLK);
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_timeout", 32'(TIMEOUT), 32'h0);
    chk("rst_master", 32'({M_DOUT, M_WE, M_RD, M_SRST}), 32'h0);
    chk("rst_cstat", 32'({C_QUEUED, C_NACK, C_STOP, C_DATA_VALID, C_DIN}), 32'h0);
    RST = 1'b0;
    @(negedge MCLK);

    // Single client write and status routing
    REQ = 2'b01; C_DOUT = 16'h006B; C_WE = 2'b01;
    #1 chk("lat_gnt", 32'(GNT), 32'h0);
    @(negedge MCLK);
    chk("s_gnt", 32'(GNT), 32'h1);
    chk("s_dout", 32'(M_DOUT), 32'h6B);
    chk("s_we", 32'(M_WE), 32'h1);
    M_QUEUED = 1'b1;
    #1 chk("s_queued", 32'(C_QUEUED), 32'h1);
    @(negedge MCLK);
    M_QUEUED = 1'b0;
    REQ = 2'b00;
    #1 chk("rel_we", 32'(M_WE), 32'h0);
    @(negedge MCLK);
    chk("rel_gnt", 32'(GNT), 32'h0);
    C_WE = 2'b00;

    // Contention straight after reset: client 0 first, then client 1
    RST = 1'b1;
    @(negedge MCLK);
    RST = 1'b0;
    @(negedge MCLK);
    REQ = 2'b11; C_DOUT = 16'hBBAA; C_WE = 2'b11;
    @(negedge MCLK);
    chk("c_gnt0", 32'(GNT), 32'h1);
    chk("c_dout0", 32'(M_DOUT), 32'hAA);
    REQ = 2'b10;
    #1 chk("c_rel_we", 32'(M_WE), 32'h0);
    @(negedge MCLK);
    chk("c_gap_gnt", 32'(GNT), 32'h0);
    t0 = tics;
    wait_cond(0, 100);
    el = tics - t0;
    chk("c_gnt1", 32'(GNT), 32'h2);
    chk("c_gap_len", 32'(el >= GAP && el <= GAP + 1), 32'h1);
    chk("c_dout1", 32'(M_DOUT), 32'hBB);
    REQ = 2'b11;

    // Read routing to owner 1
    M_DATA_VALID = 1'b1; M_DIN = 8'hA5;
    #1 chk("r_dv", 32'(C_DATA_VALID), 32'h2);
    chk("r_din", 32'(C_DIN), 32'hA5);
    @(negedge MCLK);
    M_DATA_VALID = 1'b0; M_DIN = 8'h00;
    REQ = 2'b01;
    @(negedge MCLK);
    wait_cond(0, 100);
    chk("rr_gnt0", 32'(GNT), 32'h1);

    // Watchdog: owner 0 stalls with no progress
    C_DOUT = 16'h006B; C_WE = 2'b01;
    t0 = tics;
    wait_cond(1, 5000);
    el = tics - t0;
    chk("wd_to", 32'(TIMEOUT), 32'h1);
    chk("wd_gnt", 32'(GNT), 32'h0);
    chk("wd_len", 32'(el >= WDOG && el <= WDOG + 1), 32'h1);
    chk("wd_flush", 32'({M_DOUT, M_WE, M_RD, M_SRST}), 32'h1);
    t0 = tics;
    @(negedge MCLK);
    chk("wd_pulse", 32'(TIMEOUT), 32'h0);
    wait_cond(2, 100);
    el = tics - t0;
    chk("wd_srst_len", 32'(el >= SRST && el <= SRST + 1), 32'h1);
    wait_cond(0, 100);
    chk("wd_regnt", 32'(GNT), 32'h1);

    // Watchdog clear by a progress event around TIC 1000
    t0 = tics;
    nto = 0;
    while (tics < t0 + 1000) begin
      @(negedge MCLK);
      if (TIMEOUT != 2'b00) nto++;
    end
    M_STOP = 1'b1;
    #1 chk("wc_stop", 32'(C_STOP), 32'h1);
    @(negedge MCLK);
    M_STOP = 1'b0;
    t1 = tics;
    while (tics < t1 + WDOG - 1) begin
      @(negedge MCLK);
      if (TIMEOUT != 2'b00) nto++;
    end
    chk("wc_quiet", 32'(nto), 32'h0);
    wait_cond(1, 5000);
    el = tics - t1;
    chk("wc_to", 32'(TIMEOUT), 32'h1);
    chk("wc_len", 32'(el >= WDOG && el <= WDOG + 1), 32'h1);
    wait_cond(2, 100);
    wait_cond(0, 100);
    chk("wc_regnt", 32'(GNT), 32'h1);

    // Asynchronous reset mid-read
    C_WE = 2'b00; C_RD = 2'b01;
    #1 chk("ar_rd", 32'(M_RD), 32'h1);
    @(posedge MCLK);
    #2 RST = 1'b1;
    #1 chk("ar_gnt", 32'(GNT), 32'h0);
    chk("ar_master", 32'({M_WE, M_RD, M_SRST}), 32'h0);
    @(negedge MCLK);
    RST = 1'b0; REQ = 2'b11; C_RD = 2'b00;
    @(negedge MCLK);
    chk("ar_regnt", 32'(GNT), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
